rx_link_ctrl: RTL and testbench

Link-bring-up sequencer for one Monopix2 receiver lane, in the WCLK domain next to the receiver datapath. It pulses the receiver reset and waits for 8b/10b record sync. It then qualifies the link over an error-count window, enables FIFO writes only once the lane is qualified, and retries or reports failure. It also detects loss of sync while locked and optionally relocks on its own.

---
 rtl/rx_link_pkg.sv | 29 ++
 rtl/rx_link_timer.sv | 28 ++
 rtl/rx_link_ctrl.sv | 156 +++++++++++++++
 tb/tb_rx_link_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_link_pkg.sv
// rx_link_pkg: state codes and default timing for the receiver lane bring-up.
// Shared by rx_link_ctrl, rx_link_timer and the benches.
package rx_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RST       = 3'd1,
        ST_WAIT_SYNC = 3'd2,
        ST_CHECK     = 3'd3,
        ST_LOCKED    = 3'd4,
        ST_LOST      = 3'd5,
        ST_FAILED    = 3'd6
    } link_state_e;

    localparam int RST_CYCLES_DEF       = 4;
    localparam int WAIT_SYNC_CYCLES_DEF = 1024;
    localparam int CHECK_CYCLES_DEF     = 4096;
    localparam int ERR_THRESHOLD_DEF    = 4;
    localparam int MAX_RETRIES_DEF      = 15;

    localparam logic [7:0] IDLE_KCODE = 8'h3C;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rx_link_timer.sv
// rx_link_timer: loadable down-counter; tc is high while the count sits at 0.
// One instance serves every timed state of the lane bring-up FSM.
module rx_link_timer
    import rx_link_pkg::*;
#(
    parameter int W = 12
) (
    input  logic         WCLK,
    input  logic         RESET,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge WCLK) begin
        if (RESET) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/rx_link_ctrl.sv
// rx_link_ctrl: reset/sync/qualify/lock sequencer for one receiver lane.
// Optional RX_LINK_STATS_EN adds the lost-lock counter and keeps retry_cnt on lock.
module rx_link_ctrl
    import rx_link_pkg::*;
#(
    parameter int RST_CYCLES       = RST_CYCLES_DEF,
    parameter int WAIT_SYNC_CYCLES = WAIT_SYNC_CYCLES_DEF,
    parameter int CHECK_CYCLES     = CHECK_CYCLES_DEF,
    parameter int ERR_THRESHOLD    = ERR_THRESHOLD_DEF,
    parameter int MAX_RETRIES      = MAX_RETRIES_DEF
) (
    input  logic       WCLK,
    input  logic       RESET,
    input  logic       ctrl_en,
    input  logic       start,
    input  logic       auto_relock,
    input  logic       no_8b10b_mode,
    input  logic       rec_sync_ready,
    input  logic [7:0] decoder_err_cnt,
    output logic       rx_reset,
    output logic       enable_rx,
    output logic       locked,
    output logic       failed,
    output logic [3:0] retry_cnt,
    output logic [2:0] state,
    output logic [7:0] lost_lock_cnt
);

    localparam int TW =
        $clog2(max3(RST_CYCLES, WAIT_SYNC_CYCLES, CHECK_CYCLES));

    link_state_e state_q, state_next;
    logic [TW-1:0] tload, tcount;
    logic          tc, load;
    logic          fail_att, restart;
    logic          first_chk;
    logic [7:0]    baseline_q, base_eff, delta;
    logic [3:0]    retry_q;

    rx_link_timer #(.W(TW)) u_timer (
        .WCLK     (WCLK),
        .RESET    (RESET),
        .load     (load),
        .load_val (tload),
        .count    (tcount),
        .tc       (tc)
    );

    // The baseline register is only written at the end of the first CHECK
    // cycle, so that cycle compares against the live count instead.
    assign first_chk = (state_q == ST_CHECK) &&
                       (tcount == TW'(CHECK_CYCLES - 1));
    assign base_eff  = first_chk ? decoder_err_cnt : baseline_q;
    assign delta     = decoder_err_cnt - base_eff;

    always_comb begin
        state_next = state_q;
        fail_att   = 1'b0;
        restart    = 1'b0;
        if (!ctrl_en) begin
            state_next = ST_IDLE;
        end else if (start) begin
            state_next = ST_RST;
            restart    = 1'b1;
        end else begin
            unique case (state_q)
                ST_RST: begin
                    if (tc)
                        state_next = no_8b10b_mode ? ST_LOCKED : ST_WAIT_SYNC;
                end
                ST_WAIT_SYNC: begin
                    if (rec_sync_ready) state_next = ST_CHECK;
                    else if (tc)        fail_att   = 1'b1;
                end
                ST_CHECK: begin
                    if (!rec_sync_ready) begin
                        fail_att = 1'b1;
                    end else if (tc) begin
                        if (delta > 8'(ERR_THRESHOLD) ||
                            decoder_err_cnt == 8'hFF)
                            fail_att = 1'b1;
                        else
                            state_next = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (!rec_sync_ready && !no_8b10b_mode)
                        state_next = ST_LOST;
                end
                ST_LOST: state_next = auto_relock ? ST_RST : ST_IDLE;
                default: state_next = state_q;
            endcase
            if (fail_att)
                state_next = (retry_q == 4'(MAX_RETRIES)) ? ST_FAILED : ST_RST;
        end
    end

    assign load = (state_next != state_q) || restart;

    always_comb begin
        tload = '0;
        unique case (state_next)
            ST_RST:       tload = TW'(RST_CYCLES - 1);
            ST_WAIT_SYNC: tload = TW'(WAIT_SYNC_CYCLES - 1);
            ST_CHECK:     tload = TW'(CHECK_CYCLES - 1);
            default:      tload = '0;
        endcase
    end

    always_ff @(posedge WCLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            rx_reset   <= 1'b0;
            enable_rx  <= 1'b0;
            locked     <= 1'b0;
            failed     <= 1'b0;
            retry_q    <= '0;
            baseline_q <= '0;
        end else begin
            state_q   <= state_next;
            rx_reset  <= (state_next == ST_RST);
            enable_rx <= (state_next == ST_CHECK) || (state_next == ST_LOCKED);
            locked    <= (state_next == ST_LOCKED);
            failed    <= (state_next == ST_FAILED);
            if (first_chk)
                baseline_q <= decoder_err_cnt;
            if (restart || (state_q == ST_LOST && state_next == ST_RST))
                retry_q <= '0;
            else if (fail_att && state_next == ST_RST)
                retry_q <= retry_q + 4'd1;
`ifndef RX_LINK_STATS_EN
            else if (state_next == ST_LOCKED && state_q != ST_LOCKED)
                retry_q <= '0;
`endif
        end
    end

`ifdef RX_LINK_STATS_EN
    logic [7:0] lost_q;

    always_ff @(posedge WCLK) begin
        if (RESET)
            lost_q <= '0;
        else if (state_next == ST_LOST && lost_q != 8'hFF)
            lost_q <= lost_q + 8'd1;
    end

    assign lost_lock_cnt = lost_q;
`else
    assign lost_lock_cnt = '0;
`endif

    assign retry_cnt = retry_q;
    assign state     = state_q;

endmodule

// File: tb/tb_rx_link_ctrl.sv
// tb_rx_link_ctrl: vector table, directed corner sequences and randomized
// multi-attempt bring-ups checked against a segment-level timeline model.
module tb_rx_link_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0, S_RST = 3'd1, S_WAIT = 3'd2;
    localparam logic [2:0] S_CHK = 3'd3, S_LCK = 3'd4, S_LOST = 3'd5;
    localparam logic [2:0] S_FAIL = 3'd6;

`ifdef RX_LINK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       WCLK = 1'b0;
    logic       RESET = 1'b1;
    logic       ctrl_en = 1'b0;
    logic       start = 1'b0;
    logic       auto_relock = 1'b0;
    logic       no_8b10b_mode = 1'b0;
    logic       rec_sync_ready = 1'b0;
    logic [7:0] decoder_err_cnt = 8'd0;
    logic       rx_reset, enable_rx, locked, failed;
    logic [3:0] retry_cnt;
    logic [2:0] state;
    logic [7:0] lost_lock_cnt;

    int n_pass = 0;
    int n_total = 0;

    rx_link_ctrl dut (
        .WCLK            (WCLK),
        .RESET           (RESET),
        .ctrl_en         (ctrl_en),
        .start           (start),
        .auto_relock     (auto_relock),
        .no_8b10b_mode   (no_8b10b_mode),
        .rec_sync_ready  (rec_sync_ready),
        .decoder_err_cnt (decoder_err_cnt),
        .rx_reset        (rx_reset),
        .enable_rx       (enable_rx),
        .locked          (locked),
        .failed          (failed),
        .retry_cnt       (retry_cnt),
        .state           (state),
        .lost_lock_cnt   (lost_lock_cnt)
    );

    always #5 WCLK = ~WCLK;

    // in = {ctrl_en, start, auto_relock, no_8b10b_mode, rec_sync_ready}
    // out = {rx_reset, enable_rx, locked}
    typedef struct packed {
        logic [4:0] in;
        logic [2:0] st;
        logic [2:0] out;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    logic [2:0] q_st[$];
    logic       q_sy[$];
    logic [7:0] q_er[$];

    task automatic tick();
        @(posedge WCLK);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    task automatic wait_enter(input logic [2:0] st, input int budget,
                              output int n);
        n = 0;
        while (state != st && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_leave(input logic [2:0] st, input int budget,
                              output int n);
        n = 0;
        while (state == st && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic push(input int n, input logic [2:0] s, input logic sy,
                        input logic [7:0] er);
        for (int k = 0; k < n; k++) begin
            q_st.push_back(s);
            q_sy.push_back(sy);
            q_er.push_back(er);
        end
    endtask

    initial begin
        int n, r;

        tbl[0]  = {5'b10000, S_IDLE, 3'b000};
        tbl[1]  = {5'b11010, S_RST,  3'b100};
        tbl[2]  = {5'b10010, S_RST,  3'b100};
        tbl[3]  = {5'b10010, S_RST,  3'b100};
        tbl[4]  = {5'b10010, S_RST,  3'b100};
        tbl[5]  = {5'b10010, S_LCK,  3'b011};
        tbl[6]  = {5'b10010, S_LCK,  3'b011};
        tbl[7]  = {5'b10000, S_LOST, 3'b000};
        tbl[8]  = {5'b10000, S_IDLE, 3'b000};
        tbl[9]  = {5'b01000, S_IDLE, 3'b000};
        tbl[10] = {5'b11000, S_RST,  3'b100};
        tbl[11] = {5'b11000, S_RST,  3'b100};
        tbl[12] = {5'b10000, S_RST,  3'b100};
        tbl[13] = {5'b10000, S_RST,  3'b100};
        tbl[14] = {5'b10000, S_RST,  3'b100};
        tbl[15] = {5'b10000, S_WAIT, 3'b000};
        tbl[16] = {5'b10001, S_CHK,  3'b010};
        tbl[17] = {5'b00001, S_IDLE, 3'b000};

        // synchronous reset taken from a running state
        do_reset();
        ctrl_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("rst_state", int'(state), 0);
        chk("rst_rx_reset", int'(rx_reset), 0);
        chk("rst_enable_rx", int'(enable_rx), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_failed", int'(failed), 0);
        chk("rst_retry", int'(retry_cnt), 0);
        chk("rst_lost", int'(lost_lock_cnt), 0);

        for (int i = 0; i < NV; i++) begin
            {ctrl_en, start, auto_relock, no_8b10b_mode, rec_sync_ready} =
                tbl[i].in;
            tick();
            chk($sformatf("vec%0d_state", i), int'(state), int'(tbl[i].st));
            chk($sformatf("vec%0d_outs", i),
                int'({rx_reset, enable_rx, locked}), int'(tbl[i].out));
        end
        start = 1'b0;

        // nominal bring-up: sync arrives on cycle 10 after start
        do_reset();
        ctrl_en = 1'b1;
        rec_sync_ready = 1'b0;
        decoder_err_cnt = 8'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (rx_reset && n < 20) begin
            n++;
            tick();
        end
        chk("rx_reset_len", n, 4);
        repeat (5) tick();
        rec_sync_ready = 1'b1;
        tick();
        chk("check_enable_rx", int'(enable_rx), 1);
        wait_leave(S_CHK, 5000, n);
        chk("check_len", n, 4096);
        chk("nominal_state", int'(state), 4);
        chk("nominal_locked", int'(locked), 1);
        chk("nominal_retry", int'(retry_cnt), 0);

        // +5 errors fails, +4 on the retry qualifies
        decoder_err_cnt = 8'd20;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_enter(S_CHK, 100, n);
        repeat (100) tick();
        decoder_err_cnt = 8'd25;
        wait_leave(S_CHK, 5000, n);
        chk("err5_state", int'(state), 1);
        chk("err5_retry", int'(retry_cnt), 1);
        wait_enter(S_CHK, 100, n);
        repeat (10) tick();
        decoder_err_cnt = 8'd29;
        wait_leave(S_CHK, 5000, n);
        chk("err4_state", int'(state), 4);
        chk("err4_retry", int'(retry_cnt), STATS ? 1 : 0);

        // one-cycle sync drop while locked, auto relock
        tick();
        chk("pre_drop_enable", int'(enable_rx), 1);
        rec_sync_ready = 1'b0;
        tick();
        chk("lost_state", int'(state), 5);
        chk("lost_outs", int'({enable_rx, locked}), 0);
        rec_sync_ready = 1'b1;
        auto_relock = 1'b1;
        tick();
        chk("relock_state", int'(state), 1);
        chk("relock_rx_reset", int'(rx_reset), 1);
        chk("relock_lost_cnt", int'(lost_lock_cnt), STATS ? 1 : 0);
        auto_relock = 1'b0;

        // saturated error counter with matching baseline still fails
        decoder_err_cnt = 8'hFF;
        wait_enter(S_CHK, 100, n);
        wait_leave(S_CHK, 5000, n);
        chk("sat_check_len", n, 4096);
        chk("sat_state", int'(state), 1);
        chk("sat_retry", int'(retry_cnt), 1);
        ctrl_en = 1'b0;
        tick();
        chk("ctrl_en_off_state", int'(state), 0);

        // sync never arrives: 16 attempts then FAILED
        ctrl_en = 1'b1;
        rec_sync_ready = 1'b0;
        decoder_err_cnt = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        r = 0;
        while (state != S_FAIL && n < 17000) begin
            if (rx_reset) r++;
            tick();
            n++;
        end
        chk("fail_cycle", n, 16 * (4 + 1024) + 1);
        chk("fail_rx_reset_cycles", r, 64);
        chk("fail_flag", int'(failed), 1);
        chk("fail_retry", int'(retry_cnt), 15);
        repeat (3) tick();
        chk("fail_sticky", int'(state), 6);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("fail_restart_flag", int'(failed), 0);
        chk("fail_restart_state", int'(state), 1);
        chk("fail_restart_retry", int'(retry_cnt), 0);

        // randomized attempts against the timeline model
        for (int t = 0; t < 4; t++) begin
            int na, kind, d, j, kinc, mism, got;
            logic [7:0] base, inc, fin;
            q_st.delete();
            q_sy.delete();
            q_er.delete();
            na = $urandom_range(1, 2);
            fin = 8'd0;
            for (int a = 0; a < na; a++) begin
                base = 8'($urandom_range(0, 150));
                kind = (a == na - 1) ? 0 : $urandom_range(1, 3);
                d = ($urandom_range(0, 3) == 0) ? 1023 : $urandom_range(0, 40);
                j = $urandom_range(0, 300);
                kinc = $urandom_range(1, 4095);
                inc = (kind == 3) ? 8'($urandom_range(5, 40))
                                  : 8'($urandom_range(0, 4));
                push(4, S_RST, 1'b0, base);
                if (kind == 1) begin
                    push(1024, S_WAIT, 1'b0, base);
                end else begin
                    push(d, S_WAIT, 1'b0, base);
                    push(1, S_WAIT, 1'b1, base);
                    for (int k = 0; k < 4096; k++) begin
                        if (kind == 2 && k == j) begin
                            push(1, S_CHK, 1'b0, (k >= kinc) ? base + inc : base);
                            break;
                        end
                        push(1, S_CHK, 1'b1, (k >= kinc) ? base + inc : base);
                    end
                end
                fin = base + inc;
            end
            push(3, S_LCK, 1'b1, fin);

            ctrl_en = 1'b0;
            rec_sync_ready = 1'b0;
            tick();
            ctrl_en = 1'b1;
            start = 1'b1;
            tick();
            start = 1'b0;
            mism = -1;
            got = 0;
            for (int i = 0; i < q_st.size(); i++) begin
                if (state != q_st[i] && mism < 0) begin
                    mism = i;
                    got = int'(state);
                end
                rec_sync_ready = q_sy[i];
                decoder_err_cnt = q_er[i];
                tick();
            end
            if (mism >= 0)
                $display("trial %0d diverged at cycle %0d: state %0d vs %0d",
                         t, mism + 1, got, q_st[mism]);
            chk($sformatf("rand%0d_first_bad_cycle", t), mism, -1);
            chk($sformatf("rand%0d_locked", t), int'(locked), 1);
            chk($sformatf("rand%0d_retry", t), int'(retry_cnt),
                STATS ? na - 1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
